// File: rtl/ns_arb_pkg.sv
// ns_arb_pkg
//   Shared types and helpers for the ns_rr_arb_mux arbiter.
//   arb_mode_e : arbitration policy (round-robin or fixed priority, ch0 highest)
//   rr_pick    : one-hot grant of the first set valid bit at or above ptr,
//                wrapping n-1 -> 0; all-zero when nothing is valid
package ns_arb_pkg;

   typedef enum logic {
      ARB_RR    = 1'b0,
      ARB_FIXED = 1'b1
   } arb_mode_e;

   // rr_pick works on a fixed-width vector so one function serves every
   // channel count up to MAX_CH; callers zero-extend and slice.
   localparam int MAX_CH   = 32;
   localparam int MAX_CH_W = 5;

   function automatic logic [MAX_CH-1:0] rr_pick(
      input logic [MAX_CH-1:0] valid,
      input int                ptr,
      input int                n
   );
      logic [MAX_CH-1:0] grant;
      logic              found;
      int                idx;
      grant = '0;
      found = 1'b0;
      for (int i = 0; i < MAX_CH; i++) begin
         if (i < n) begin
            // ptr < n always holds, so a single subtraction performs the wrap
            idx = ptr + i;
            if (idx >= n) idx = idx - n;
            if (!found && valid[idx[MAX_CH_W-1:0]]) begin
               grant[idx[MAX_CH_W-1:0]] = 1'b1;
               found                    = 1'b1;
            end
         end
      end
      return grant;
   endfunction

endpackage

// File: rtl/ns_mux1h.sv
// ns_mux1h
//   Combinational one-hot multiplexer (AND-OR). An all-zero select yields zero.
//   i_sel  [SEL_WIDTH]             one-hot select
//   i_data [SEL_WIDTH*DATA_WIDTH]  input i in bits [i*DATA_WIDTH +: DATA_WIDTH]
//   o_data [DATA_WIDTH]            selected payload
module ns_mux1h #(
   parameter int DATA_WIDTH = 32,
   parameter int SEL_WIDTH  = 4
) (
   input  logic [SEL_WIDTH-1:0]            i_sel,
   input  logic [SEL_WIDTH*DATA_WIDTH-1:0] i_data,
   output logic [DATA_WIDTH-1:0]           o_data
);

   always_comb begin
      o_data = '0;
      for (int i = 0; i < SEL_WIDTH; i++) begin
         o_data = o_data | (i_data[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{i_sel[i]}});
      end
   end

endmodule

// File: rtl/ns_rr_arb_mux.sv
// ns_rr_arb_mux
//   N-channel valid/ready arbiter feeding one registered output stage.
//   The winner is chosen by round-robin (search starts at rr_ptr) or fixed
//   priority (search starts at ch0); its payload is registered with its index.
//   clk        clock, rising edge
//   rst_n      synchronous reset, active low
//   in_valid   per-channel request             [N_CH]
//   in_data    packed channel payloads         [N_CH*DATA_WIDTH]
//   in_ready   per-channel accept, one-hot0    [N_CH]
//   out_valid  registered payload valid
//   out_data   registered payload              [DATA_WIDTH]
//   out_ch     source channel of out_data      [CH_W]
//   out_ready  downstream accept
//   N_CH must not exceed ns_arb_pkg::MAX_CH.
module ns_rr_arb_mux
   import ns_arb_pkg::*;
#(
   parameter int        DATA_WIDTH = 32,
   parameter int        N_CH       = 4,
   parameter arb_mode_e ARB_MODE   = ARB_RR,
   localparam int       CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [N_CH-1:0]            in_valid,
   input  logic [N_CH*DATA_WIDTH-1:0] in_data,
   output logic [N_CH-1:0]            in_ready,
   output logic                       out_valid,
   output logic [DATA_WIDTH-1:0]      out_data,
   output logic [CH_W-1:0]            out_ch,
   input  logic                       out_ready
);

   logic                  r_out_valid;
   logic [DATA_WIDTH-1:0] r_out_data;
   logic [CH_W-1:0]       r_out_ch;
   logic [CH_W-1:0]       r_rr_ptr;

   logic                  w_load_en;
   logic                  w_xfer;
   logic [CH_W-1:0]       w_ptr;
   logic [MAX_CH-1:0]     w_valid_ext;
   logic [MAX_CH-1:0]     w_pick;
   logic                  w_unused_hi;
   logic [N_CH-1:0]       w_grant;
   logic [CH_W-1:0]       w_grant_idx;
   logic [CH_W-1:0]       w_ptr_next;
   logic [DATA_WIDTH-1:0] w_mux_data;

   // the output register can take new data when empty or being popped
   assign w_load_en = !r_out_valid || out_ready;
   assign w_ptr     = (ARB_MODE == ARB_FIXED) ? '0 : r_rr_ptr;

   always_comb begin
      w_valid_ext             = '0;
      w_valid_ext[N_CH-1:0]   = in_valid;
   end

   assign w_pick = rr_pick(w_valid_ext, int'(w_ptr), N_CH);

   // bits above N_CH are always zero; folded here only so they are consumed
   always_comb begin
      w_unused_hi = 1'b0;
      for (int i = N_CH; i < MAX_CH; i++) begin
         w_unused_hi = w_unused_hi | w_pick[i];
      end
   end

   assign w_grant = w_pick[N_CH-1:0];

   always_comb begin
      w_grant_idx = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (w_grant[i]) w_grant_idx = CH_W'(i);
      end
   end

   assign w_ptr_next = (w_grant_idx == CH_W'(N_CH-1)) ? '0 : w_grant_idx + CH_W'(1);

   // a non-zero grant exists exactly when some channel is valid
   assign w_xfer   = w_load_en && (|in_valid);
   assign in_ready = rst_n ? (w_grant & {N_CH{w_load_en}}) : '0;

   ns_mux1h #(
      .DATA_WIDTH (DATA_WIDTH),
      .SEL_WIDTH  (N_CH)
   ) u_data_mux (
      .i_sel  (w_grant),
      .i_data (in_data),
      .o_data (w_mux_data)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_ch    <= '0;
         r_rr_ptr    <= '0;
      end else if (w_load_en) begin
         if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_mux_data;
            r_out_ch    <= w_grant_idx;
            if (ARB_MODE == ARB_RR) r_rr_ptr <= w_ptr_next;
         end else begin
            // drain: payload and index keep their last values
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_ch    = r_out_ch;

endmodule

// File: tb/tb_ns_rr_arb_mux.sv
module tb_ns_rr_arb_mux;
   import ns_arb_pkg::*;

   localparam int DW = 32;
   localparam int NC = 4;
   localparam int CW = 2;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [NC*DW-1:0] in_data;
   assign in_data = {32'h0000_00A3, 32'h0000_00A2, 32'h0000_00A1, 32'h0000_00A0};

   logic [NC-1:0] a_in_valid, a_in_ready, b_in_valid, b_in_ready;
   logic          a_out_valid, a_out_ready, b_out_valid, b_out_ready;
   logic [DW-1:0] a_out_data, b_out_data;
   logic [CW-1:0] a_out_ch, b_out_ch;

   ns_rr_arb_mux #(.DATA_WIDTH(DW), .N_CH(NC), .ARB_MODE(ARB_RR)) u_dut_rr (
      .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_data(in_data),
      .in_ready(a_in_ready), .out_valid(a_out_valid), .out_data(a_out_data),
      .out_ch(a_out_ch), .out_ready(a_out_ready)
   );

   ns_rr_arb_mux #(.DATA_WIDTH(DW), .N_CH(NC), .ARB_MODE(ARB_FIXED)) u_dut_fx (
      .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_data(in_data),
      .in_ready(b_in_ready), .out_valid(b_out_valid), .out_data(b_out_data),
      .out_ch(b_out_ch), .out_ready(b_out_ready)
   );

   a_rr_onehot: assert property (@(posedge clk) $onehot0(a_in_ready));
   a_fx_onehot: assert property (@(posedge clk) $onehot0(b_in_ready));
   a_rr_stall:  assert property (@(posedge clk)
      (rst_n && a_out_valid && !a_out_ready) |=> ($stable(a_out_data) && $stable(a_out_ch)));
   a_fx_stall:  assert property (@(posedge clk)
      (rst_n && b_out_valid && !b_out_ready) |=> ($stable(b_out_data) && $stable(b_out_ch)));

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [3:0]  v;     // in_valid this cycle
      logic        r;     // out_ready this cycle
      logic [3:0]  rdy;   // expected in_ready this cycle
      logic        ov;    // expected out_valid after the edge
      logic [1:0]  ch;    // expected out_ch after the edge
      logic [31:0] d;     // expected out_data after the edge
   } vec_t;

   vec_t tbl[20];

   initial begin
      // round-robin run, continuous from reset release (rr_ptr starts at 0)
      tbl[0]  = '{4'hF,    1'b1, 4'b0001, 1'b1, 2'd0, 32'hA0};
      tbl[1]  = '{4'hF,    1'b1, 4'b0010, 1'b1, 2'd1, 32'hA1};
      tbl[2]  = '{4'hF,    1'b1, 4'b0100, 1'b1, 2'd2, 32'hA2};
      tbl[3]  = '{4'hF,    1'b1, 4'b1000, 1'b1, 2'd3, 32'hA3};
      tbl[4]  = '{4'hF,    1'b1, 4'b0001, 1'b1, 2'd0, 32'hA0};
      // backpressure for 5 cycles
      tbl[5]  = '{4'hF,    1'b0, 4'b0000, 1'b1, 2'd0, 32'hA0};
      tbl[6]  = '{4'hF,    1'b0, 4'b0000, 1'b1, 2'd0, 32'hA0};
      tbl[7]  = '{4'hF,    1'b0, 4'b0000, 1'b1, 2'd0, 32'hA0};
      tbl[8]  = '{4'hF,    1'b0, 4'b0000, 1'b1, 2'd0, 32'hA0};
      tbl[9]  = '{4'hF,    1'b0, 4'b0000, 1'b1, 2'd0, 32'hA0};
      tbl[10] = '{4'hF,    1'b1, 4'b0010, 1'b1, 2'd1, 32'hA1};
      // bring rr_ptr to 3, then wrap/skip with 0101
      tbl[11] = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 32'hA2};
      tbl[12] = '{4'b0101, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hA0};
      tbl[13] = '{4'b0101, 1'b1, 4'b0100, 1'b1, 2'd2, 32'hA2};
      // drain, idle empty, reload while empty, stall, pop+accept
      tbl[14] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 32'hA2};
      tbl[15] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd2, 32'hA2};
      tbl[16] = '{4'b1000, 1'b0, 4'b1000, 1'b1, 2'd3, 32'hA3};
      tbl[17] = '{4'b0001, 1'b0, 4'b0000, 1'b1, 2'd3, 32'hA3};
      tbl[18] = '{4'b0011, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hA0};
      tbl[19] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 2'd0, 32'hA0};

      // T1 reset with all channels requesting
      rst_n       = 1'b0;
      a_in_valid  = 4'hF;
      b_in_valid  = 4'hF;
      a_out_ready = 1'b1;
      b_out_ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         #1;
         check("rst_in_ready_rr", 32'(a_in_ready), 32'h0);
         check("rst_in_ready_fx", 32'(b_in_ready), 32'h0);
      end
      check("rst_out_valid_rr", 32'(a_out_valid), 32'h0);
      check("rst_out_data_rr",  a_out_data,       32'h0);
      check("rst_out_ch_rr",    32'(a_out_ch),    32'h0);
      check("rst_out_valid_fx", 32'(b_out_valid), 32'h0);
      check("rst_out_data_fx",  b_out_data,       32'h0);
      rst_n      = 1'b1;
      b_in_valid = 4'h0;

      // T2/T3/T4 table on the round-robin instance
      for (int i = 0; i < 20; i++) begin
         a_in_valid  = tbl[i].v;
         a_out_ready = tbl[i].r;
         #1;
         check($sformatf("v%0d_in_ready", i), 32'(a_in_ready), 32'(tbl[i].rdy));
         @(posedge clk);
         #1;
         check($sformatf("v%0d_out_valid", i), 32'(a_out_valid), 32'(tbl[i].ov));
         check($sformatf("v%0d_out_ch", i),    32'(a_out_ch),    32'(tbl[i].ch));
         check($sformatf("v%0d_out_data", i),  a_out_data,       tbl[i].d);
         @(negedge clk);
      end

      // T6 reset while stalled with valid output (rr_ptr is 1 here)
      a_in_valid  = 4'hF;
      a_out_ready = 1'b0;
      rst_n       = 1'b0;
      #1;
      check("t6_in_ready_rst", 32'(a_in_ready), 32'h0);
      @(posedge clk);
      #1;
      check("t6_out_valid", 32'(a_out_valid), 32'h0);
      check("t6_out_data",  a_out_data,       32'h0);
      check("t6_out_ch",    32'(a_out_ch),    32'h0);
      @(negedge clk);
      rst_n       = 1'b1;
      a_out_ready = 1'b1;
      #1;
      check("t6_restart_ready", 32'(a_in_ready), 32'b0001);
      @(posedge clk);
      #1;
      check("t6_restart_ch",   32'(a_out_ch), 32'h0);
      check("t6_restart_data", a_out_data,    32'hA0);
      @(negedge clk);
      #1;
      check("t6_next_ready", 32'(a_in_ready), 32'b0010);
      @(posedge clk);
      #1;
      check("t6_next_ch", 32'(a_out_ch), 32'h1);
      @(negedge clk);
      a_in_valid = 4'h0;

      // T5 fixed priority: ch1 always beats ch3
      b_in_valid  = 4'b1010;
      b_out_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         #1;
         check($sformatf("t5_c%0d_in_ready", c), 32'(b_in_ready), 32'b0010);
         @(posedge clk);
         #1;
         check($sformatf("t5_c%0d_out_valid", c), 32'(b_out_valid), 32'h1);
         check($sformatf("t5_c%0d_out_ch", c),    32'(b_out_ch),    32'h1);
         check($sformatf("t5_c%0d_out_data", c),  b_out_data,       32'hA1);
         @(negedge clk);
      end
      b_out_ready = 1'b0;
      #1;
      check("t5_stall_ready", 32'(b_in_ready), 32'h0);
      @(posedge clk);
      #1;
      check("t5_stall_ch", 32'(b_out_ch), 32'h1);
      @(negedge clk);
      b_in_valid  = 4'b1000;
      b_out_ready = 1'b1;
      #1;
      check("t5_alone_ready", 32'(b_in_ready), 32'b1000);
      @(posedge clk);
      #1;
      check("t5_alone_ch",   32'(b_out_ch), 32'h3);
      check("t5_alone_data", b_out_data,    32'hA3);
      @(negedge clk);
      b_in_valid = 4'h0;
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
